// File: rtl/game_ctrl_pkg.sv
// Shared types and default widths for the target/torpedo round controller.
package game_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SPAWN,
        AIM,
        LAUNCH,
        FLIGHT,
        HIT,
        MISS,
        WAIT,
        OVER
    } state_t;

    localparam int unsigned LIVES_W = 3;
    localparam int unsigned LEVEL_W = 3;

endpackage

// File: rtl/game_round_ctrl_if.sv
// Sprite, overlap and timer handshake between the round controller and its peripherals.
interface game_round_ctrl_if;

    logic sprite_target_write_xy;
    logic sprite_target_write_dxy;
    logic sprite_torpedo_write_xy;
    logic sprite_torpedo_write_dxy;
    logic sprite_target_enable_update;
    logic sprite_torpedo_enable_update;
    logic sprite_target_within_screen;
    logic sprite_torpedo_within_screen;
    logic collision;
    logic end_of_game_timer_start;
    logic end_of_game_timer_running;

    modport master (
        output sprite_target_write_xy,
        output sprite_target_write_dxy,
        output sprite_torpedo_write_xy,
        output sprite_torpedo_write_dxy,
        output sprite_target_enable_update,
        output sprite_torpedo_enable_update,
        output end_of_game_timer_start,
        input  sprite_target_within_screen,
        input  sprite_torpedo_within_screen,
        input  collision,
        input  end_of_game_timer_running
    );

    modport slave (
        input  sprite_target_write_xy,
        input  sprite_target_write_dxy,
        input  sprite_torpedo_write_xy,
        input  sprite_torpedo_write_dxy,
        input  sprite_target_enable_update,
        input  sprite_torpedo_enable_update,
        input  end_of_game_timer_start,
        output sprite_target_within_screen,
        output sprite_torpedo_within_screen,
        output collision,
        output end_of_game_timer_running
    );

endinterface

// File: rtl/game_round_stats.sv
// Lives, score, level and hit counters; all saturate instead of wrapping.
module game_round_stats
    import game_ctrl_pkg::*;
#(
    parameter int unsigned LIVES_INIT     = 3,
    parameter int unsigned SCORE_W        = 8,
    parameter int unsigned HITS_PER_LEVEL = 4,
    parameter int unsigned MAX_LEVEL      = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hit,
    input  logic               miss,
    input  logic               new_game,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic [LEVEL_W-1:0] level
);

    localparam int unsigned HIT_CNT_W = $clog2(HITS_PER_LEVEL + 1);
    localparam logic [HIT_CNT_W-1:0] HIT_LAST  = HIT_CNT_W'(HITS_PER_LEVEL - 1);
    localparam logic [LEVEL_W-1:0]   LEVEL_MAX = LEVEL_W'(MAX_LEVEL);
    localparam logic [LIVES_W-1:0]   LIVES_RST = LIVES_W'(LIVES_INIT);
    localparam logic [SCORE_W-1:0]   SCORE_MAX = '1;

    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [HIT_CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    always_comb begin
        lives_d   = lives_q;
        score_d   = score_q;
        level_d   = level_q;
        hit_cnt_d = hit_cnt_q;
        if (new_game) begin
            lives_d   = LIVES_RST;
            score_d   = '0;
            level_d   = '0;
            hit_cnt_d = '0;
        end else if (hit) begin
            if (score_q != SCORE_MAX) begin
                score_d = score_q + 1'b1;
            end
            // hit_cnt keeps cycling after level saturates so it never overflows
            if (hit_cnt_q == HIT_LAST) begin
                hit_cnt_d = '0;
                if (level_q != LEVEL_MAX) begin
                    level_d = level_q + 1'b1;
                end
            end else begin
                hit_cnt_d = hit_cnt_q + 1'b1;
            end
        end else if (miss) begin
            if (lives_q != '0) begin
                lives_d = lives_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lives_q   <= LIVES_RST;
            score_q   <= '0;
            level_q   <= '0;
            hit_cnt_q <= '0;
        end else begin
            lives_q   <= lives_d;
            score_q   <= score_d;
            level_q   <= level_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign lives = lives_q;
    assign score = score_q;
    assign level = level_q;

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: spawns target, launches torpedo, classifies hit/miss, paces rounds.
module game_round_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int unsigned LIVES_INIT     = 3,
    parameter int unsigned SCORE_W        = 8,
    parameter int unsigned HITS_PER_LEVEL = 4,
    parameter int unsigned MAX_LEVEL      = 7,
    parameter int unsigned GUARD_CYCLES   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               launch_key,
    game_round_ctrl_if.master  bus,
    output logic               game_won,
    output logic               game_over,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic [LEVEL_W-1:0] level
);

    localparam int unsigned GUARD_W = $clog2(GUARD_CYCLES + 1);
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES);

    state_t             state_q, state_d;
    logic [GUARD_W-1:0] guard_q, guard_d;
    logic               launch_key_q;
    logic               launch_edge;
    logic               wait_first_q;

    logic tgt_write_xy_q, tgt_write_dxy_q, tgt_enable_q;
    logic trp_write_xy_q, trp_write_dxy_q, trp_enable_q;
    logic timer_start_q;

    assign launch_edge = launch_key & ~launch_key_q;

    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        unique case (state_q)
            IDLE: begin
                if (launch_edge) state_d = SPAWN;
            end
            SPAWN: begin
                state_d = AIM;
                guard_d = GUARD_LOAD;
            end
            AIM: begin
                // freshly written sprites need a few cycles before their status is trustworthy
                if (guard_q != '0) begin
                    guard_d = guard_q - 1'b1;
                end else if (!bus.sprite_target_within_screen) begin
                    state_d = MISS;
                end else if (launch_edge) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = FLIGHT;
                guard_d = GUARD_LOAD;
            end
            FLIGHT: begin
                if (guard_q != '0) begin
                    guard_d = guard_q - 1'b1;
                end else if (bus.collision) begin
                    state_d = HIT;
                end else if (!bus.sprite_target_within_screen ||
                             !bus.sprite_torpedo_within_screen) begin
                    state_d = MISS;
                end
            end
            HIT, MISS: begin
                state_d = WAIT;
            end
            WAIT: begin
                // the timer's busy flag lags its start pulse by a cycle
                if (!wait_first_q && !bus.end_of_game_timer_running) begin
                    state_d = (lives == '0) ? OVER : SPAWN;
                end
            end
            OVER: begin
                if (launch_edge) state_d = SPAWN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            guard_q         <= '0;
            launch_key_q    <= 1'b0;
            wait_first_q    <= 1'b0;
            tgt_write_xy_q  <= 1'b0;
            tgt_write_dxy_q <= 1'b0;
            tgt_enable_q    <= 1'b0;
            trp_write_xy_q  <= 1'b0;
            trp_write_dxy_q <= 1'b0;
            trp_enable_q    <= 1'b0;
            timer_start_q   <= 1'b0;
            game_won        <= 1'b0;
            game_over       <= 1'b0;
        end else begin
            state_q         <= state_d;
            guard_q         <= guard_d;
            launch_key_q    <= launch_key;
            wait_first_q    <= (state_d == WAIT) && (state_q != WAIT);
            tgt_write_xy_q  <= (state_d == SPAWN);
            tgt_write_dxy_q <= (state_d == SPAWN);
            trp_write_xy_q  <= (state_d == SPAWN);
            trp_write_dxy_q <= (state_d == SPAWN) || (state_d == LAUNCH);
            tgt_enable_q    <= (state_d == AIM) || (state_d == LAUNCH) || (state_d == FLIGHT);
            trp_enable_q    <= (state_d == FLIGHT);
            timer_start_q   <= (state_d == HIT) || (state_d == MISS);

            if (state_d == HIT) begin
                game_won <= 1'b1;
            end else if (state_d == MISS) begin
                game_won <= 1'b0;
            end else if (state_q == WAIT && state_d != WAIT) begin
                game_won <= 1'b0;
            end

            if (state_d == OVER) begin
                game_over <= 1'b1;
            end else if (state_q == OVER) begin
                game_over <= 1'b0;
            end
        end
    end

    assign bus.sprite_target_write_xy       = tgt_write_xy_q;
    assign bus.sprite_target_write_dxy      = tgt_write_dxy_q;
    assign bus.sprite_torpedo_write_xy      = trp_write_xy_q;
    assign bus.sprite_torpedo_write_dxy     = trp_write_dxy_q;
    assign bus.sprite_target_enable_update  = tgt_enable_q;
    assign bus.sprite_torpedo_enable_update = trp_enable_q;
    assign bus.end_of_game_timer_start      = timer_start_q;

    game_round_stats #(
        .LIVES_INIT     (LIVES_INIT),
        .SCORE_W        (SCORE_W),
        .HITS_PER_LEVEL (HITS_PER_LEVEL),
        .MAX_LEVEL      (MAX_LEVEL)
    ) u_stats (
        .clk      (clk),
        .rst      (rst),
        .hit      (state_d == HIT),
        .miss     (state_d == MISS),
        .new_game ((state_q == OVER) && launch_edge),
        .lives    (lives),
        .score    (score),
        .level    (level)
    );

endmodule

// File: tb/tb_game_round_ctrl.sv
// Randomized round-level bench for game_round_ctrl against a counting reference model.
module tb_game_round_ctrl;
    import game_ctrl_pkg::*;

    localparam int unsigned LIVES_INIT     = 3;
    localparam int unsigned SCORE_W        = 8;
    localparam int unsigned HITS_PER_LEVEL = 4;
    localparam int unsigned MAX_LEVEL      = 7;
    localparam int unsigned GUARD_CYCLES   = 4;
    localparam int          SCORE_SAT      = (1 << SCORE_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               launch_key;
    logic               game_won;
    logic               game_over;
    logic [LIVES_W-1:0] lives;
    logic [SCORE_W-1:0] score;
    logic [LEVEL_W-1:0] level;

    game_round_ctrl_if bus_if ();

    game_round_ctrl #(
        .LIVES_INIT     (LIVES_INIT),
        .SCORE_W        (SCORE_W),
        .HITS_PER_LEVEL (HITS_PER_LEVEL),
        .MAX_LEVEL      (MAX_LEVEL),
        .GUARD_CYCLES   (GUARD_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .launch_key (launch_key),
        .bus        (bus_if),
        .game_won   (game_won),
        .game_over  (game_over),
        .lives      (lives),
        .score      (score),
        .level      (level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    // reference model: lives left and hits since the last new game
    int m_lives;
    int m_hits;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_score();
        return (m_hits > SCORE_SAT) ? SCORE_SAT : m_hits;
    endfunction

    function automatic int exp_level();
        int l;
        l = m_hits / HITS_PER_LEVEL;
        return (l > MAX_LEVEL) ? MAX_LEVEL : l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clean_inputs();
        bus_if.sprite_target_within_screen  = 1'b1;
        bus_if.sprite_torpedo_within_screen = 1'b1;
        bus_if.collision                    = 1'b0;
        bus_if.end_of_game_timer_running    = 1'b0;
    endtask

    task automatic check_stats(input string tag);
        check_val({tag, "_lives"}, int'(lives), m_lives);
        check_val({tag, "_score"}, int'(score), exp_score());
        check_val({tag, "_level"}, int'(level), exp_level());
    endtask

    // Called one sample after HIT/MISS is visible; walks the end-of-round wait.
    task automatic wait_phase(input bit won, input bit abort);
        int d;
        int exit_t;
        clean_inputs();
        launch_key = 1'($urandom_range(0, 1));
        d = $urandom_range(0, 5);
        bus_if.end_of_game_timer_running = (d > 0);
        exit_t = (d + 1 > 3) ? d + 1 : 3;
        for (int t = 1; t <= exit_t; t++) begin
            tick();
            launch_key = 1'b0;
            if (t >= d) bus_if.end_of_game_timer_running = 1'b0;
            if (abort) return;
            check_val("wait_no_timer", int'(bus_if.end_of_game_timer_start), 0);
            if (t < exit_t) begin
                check_val("wait_hold_xy", int'(bus_if.sprite_target_write_xy), 0);
                check_val("wait_won", int'(game_won), int'(won));
                check_val("wait_over", int'(game_over), 0);
            end else if (m_lives == 0) begin
                check_val("over_flag", int'(game_over), 1);
                check_val("over_no_spawn", int'(bus_if.sprite_target_write_xy), 0);
                check_stats("over_hold");
            end else begin
                check_val("respawn_xy", int'(bus_if.sprite_target_write_xy), 1);
                check_val("respawn_won_clr", int'(game_won), 0);
            end
        end
    endtask

    // kind: 0 hit, 1 target leaves screen while aiming, 2 miss in flight.
    // Entered with SPAWN outputs visible.
    task automatic play_round(input int kind, input bit abort);
        bit won;
        clean_inputs();
        launch_key = 1'b0;
        tick();
        check_val("aim_tgt_en", int'(bus_if.sprite_target_enable_update), 1);
        check_val("aim_trp_en", int'(bus_if.sprite_torpedo_enable_update), 0);
        if (kind == 1) bus_if.sprite_target_within_screen = 1'b0;
        else launch_key = 1'($urandom_range(0, 1));
        for (int i = 0; i < GUARD_CYCLES; i++) begin
            tick();
            launch_key = 1'b0;
            check_val("aim_guard_timer", int'(bus_if.end_of_game_timer_start), 0);
            check_val("aim_guard_launch", int'(bus_if.sprite_torpedo_write_dxy), 0);
        end
        if (kind == 1) begin
            tick();
            if (m_lives > 0) m_lives--;
            check_val("aim_miss_timer", int'(bus_if.end_of_game_timer_start), 1);
            check_val("aim_miss_won", int'(game_won), 0);
            check_stats("aim_miss");
            wait_phase(1'b0, abort);
            return;
        end
        repeat ($urandom_range(0, 2)) begin
            tick();
            check_val("aim_idle", int'(bus_if.sprite_torpedo_write_dxy), 0);
        end
        launch_key = 1'b1;
        tick();
        check_val("launch_dxy", int'(bus_if.sprite_torpedo_write_dxy), 1);
        check_val("launch_no_tgt", int'(bus_if.sprite_target_write_dxy), 0);
        check_val("launch_tgt_en", int'(bus_if.sprite_target_enable_update), 1);
        tick();
        check_val("flight_trp_en", int'(bus_if.sprite_torpedo_enable_update), 1);
        check_val("flight_tgt_en", int'(bus_if.sprite_target_enable_update), 1);
        // noise inside the guard window must be ignored
        for (int i = 0; i < GUARD_CYCLES; i++) begin
            bus_if.collision                    = 1'($urandom_range(0, 1));
            bus_if.sprite_target_within_screen  = 1'($urandom_range(0, 1));
            bus_if.sprite_torpedo_within_screen = 1'($urandom_range(0, 1));
            tick();
            check_val("flight_guard_timer", int'(bus_if.end_of_game_timer_start), 0);
        end
        clean_inputs();
        repeat ($urandom_range(0, 2)) begin
            tick();
            check_val("flight_idle_timer", int'(bus_if.end_of_game_timer_start), 0);
            check_val("flight_one_launch", int'(bus_if.sprite_torpedo_write_dxy), 0);
        end
        launch_key = 1'b0;
        if (kind == 0) begin
            bus_if.collision                    = 1'b1;
            bus_if.sprite_target_within_screen  = 1'($urandom_range(0, 1));
            bus_if.sprite_torpedo_within_screen = 1'($urandom_range(0, 1));
            m_hits++;
            won = 1'b1;
        end else begin
            if ($urandom_range(0, 1) == 1) bus_if.sprite_target_within_screen = 1'b0;
            else bus_if.sprite_torpedo_within_screen = 1'b0;
            if (m_lives > 0) m_lives--;
            won = 1'b0;
        end
        tick();
        check_val("outcome_timer", int'(bus_if.end_of_game_timer_start), 1);
        check_val("outcome_won", int'(game_won), int'(won));
        check_stats("outcome");
        wait_phase(won, abort);
    endtask

    // Entered with OVER visible.
    task automatic new_game();
        launch_key = 1'b0;
        tick();
        check_val("over_stays", int'(game_over), 1);
        launch_key = 1'b1;
        tick();
        launch_key = 1'b0;
        m_lives = LIVES_INIT;
        m_hits  = 0;
        check_val("newgame_spawn", int'(bus_if.sprite_target_write_xy), 1);
        check_val("newgame_over_clr", int'(game_over), 0);
        check_stats("newgame");
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_xy"}, int'(bus_if.sprite_target_write_xy), 0);
        check_val({tag, "_tgt_en"}, int'(bus_if.sprite_target_enable_update), 0);
        check_val({tag, "_trp_en"}, int'(bus_if.sprite_torpedo_enable_update), 0);
        check_val({tag, "_timer"}, int'(bus_if.end_of_game_timer_start), 0);
        check_val({tag, "_won"}, int'(game_won), 0);
        check_val({tag, "_over"}, int'(game_over), 0);
        check_val({tag, "_lives"}, int'(lives), LIVES_INIT);
        check_val({tag, "_score"}, int'(score), 0);
        check_val({tag, "_level"}, int'(level), 0);
    endtask

    initial begin
        rst        = 1'b1;
        launch_key = 1'b0;
        clean_inputs();
        m_lives = LIVES_INIT;
        m_hits  = 0;
        #1;
        check_reset_outputs("reset");
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        check_val("idle_no_spawn", int'(bus_if.sprite_target_write_xy), 0);

        launch_key = 1'b1;
        tick();
        check_val("spawn_tgt_xy", int'(bus_if.sprite_target_write_xy), 1);
        check_val("spawn_tgt_dxy", int'(bus_if.sprite_target_write_dxy), 1);
        check_val("spawn_trp_xy", int'(bus_if.sprite_torpedo_write_xy), 1);
        check_val("spawn_trp_dxy", int'(bus_if.sprite_torpedo_write_dxy), 1);
        check_stats("spawn");

        repeat (30) begin
            play_round($urandom_range(0, 2), 1'b0);
            if (m_lives == 0) new_game();
        end

        while (m_lives > 0) play_round($urandom_range(1, 2), 1'b0);
        new_game();
        repeat (262) play_round(0, 1'b0);
        check_val("score_sat", int'(score), SCORE_SAT);
        check_val("level_sat", int'(level), MAX_LEVEL);
        repeat (LIVES_INIT) play_round(1, 1'b0);
        check_val("final_over", int'(game_over), 1);
        new_game();

        play_round(0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clean_inputs();
        repeat (10) begin
            tick();
            check_val("post_rst_timer", int'(bus_if.end_of_game_timer_start), 0);
            check_val("post_rst_idle", int'(bus_if.sprite_target_write_xy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
